uart_bus_master: RTL and testbench

//  UART debug initiator for the picorv32-style memory bus: receives framed commands over a

---
 rtl/uart_bus_master.sv | 213 +++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART debug bus initiator: framed W/R commands from a byte stream drive single 32-bit accesses.
// Optional checksum byte on frames and read replies when UART_BUS_MASTER_CSUM_EN is defined.
module uart_bus_master #(
    parameter int RX_TIMEOUT  = 2000000,
    parameter int BUS_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        rx_read,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        tx_write,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] REP_BAD = 8'h3F;
    localparam logic [7:0] REP_OK  = 8'h4B;
    localparam logic [7:0] REP_TMO = 8'h54;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM, S_BUS, S_RESP} state_t;

`ifdef UART_BUS_MASTER_CSUM_EN
    localparam state_t PAYLOAD_END = S_CSUM;
    localparam logic [7:0] REP_ERR = 8'h45;
    logic [7:0] csum;
    logic       resp_tail;
`else
    localparam state_t PAYLOAD_END = S_BUS;
`endif

    state_t      state, state_next;
    logic [1:0]  cnt;
    logic [31:0] tmo;
    logic        rx_skip;
    logic        is_write;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  resp_code;
    logic        resp_multi;
    logic        take, tx_fire, resp_last, rx_tmo, bus_tmo;
    logic [7:0]  resp_byte;

    always_comb begin
        take    = rx_ready && !rx_skip;
        rx_tmo  = (tmo == 32'(RX_TIMEOUT - 1));
        bus_tmo = (tmo == 32'(BUS_TIMEOUT - 1));

        resp_byte = resp_code;
        if (resp_multi) begin
            case (cnt)
                2'd0:    resp_byte = rdata[31:24];
                2'd1:    resp_byte = rdata[23:16];
                2'd2:    resp_byte = rdata[15:8];
                default: resp_byte = rdata[7:0];
            endcase
        end
`ifdef UART_BUS_MASTER_CSUM_EN
        if (resp_multi && resp_tail)
            resp_byte = rdata[31:24] ^ rdata[23:16] ^ rdata[15:8] ^ rdata[7:0];
        resp_last = !resp_multi || resp_tail;
`else
        resp_last = !resp_multi || (cnt == 2'd3);
`endif
    end

    always_comb begin
        state_next = state;
        rx_read    = 1'b0;
        tx_fire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (take) begin
                    rx_read    = 1'b1;
                    state_next = (rx_data == CMD_W || rx_data == CMD_R) ? S_ADDR : S_RESP;
                end
            end
            S_ADDR: begin
                if (take) begin
                    rx_read = 1'b1;
                    if (cnt == 2'd3)
                        state_next = is_write ? S_DATA : PAYLOAD_END;
                end else if (rx_tmo) begin
                    state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (take) begin
                    rx_read = 1'b1;
                    if (cnt == 2'd3)
                        state_next = PAYLOAD_END;
                end else if (rx_tmo) begin
                    state_next = S_IDLE;
                end
            end
`ifdef UART_BUS_MASTER_CSUM_EN
            S_CSUM: begin
                if (take) begin
                    rx_read    = 1'b1;
                    state_next = (rx_data == csum) ? S_BUS : S_RESP;
                end else if (rx_tmo) begin
                    state_next = S_IDLE;
                end
            end
`endif
            S_BUS: begin
                // Ready takes priority over a simultaneous timeout.
                if (mem_ready || bus_tmo)
                    state_next = S_RESP;
            end
            S_RESP: begin
                // tx_write high means tx_ready is not re-sampled this cycle.
                if (tx_ready && !tx_write) begin
                    tx_fire = 1'b1;
                    if (resp_last)
                        state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cnt        <= 2'd0;
            tmo        <= 32'd0;
            rx_skip    <= 1'b0;
            tx_write   <= 1'b0;
            tx_data    <= 8'h00;
            is_write   <= 1'b0;
            resp_code  <= 8'h00;
            resp_multi <= 1'b0;
`ifdef UART_BUS_MASTER_CSUM_EN
            csum       <= 8'h00;
            resp_tail  <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            rx_skip  <= rx_read;
            tx_write <= tx_fire;
            if (state_next != state || rx_read || state == S_IDLE)
                tmo <= 32'd0;
            else
                tmo <= tmo + 32'd1;
            if (tx_fire)
                tx_data <= resp_byte;
            case (state)
                S_IDLE: if (rx_read) begin
                    is_write   <= (rx_data == CMD_W);
                    resp_code  <= REP_BAD;
                    resp_multi <= 1'b0;
                    cnt        <= 2'd0;
`ifdef UART_BUS_MASTER_CSUM_EN
                    csum       <= rx_data;
`endif
                end
                S_ADDR: if (rx_read) begin
                    addr <= {addr[23:0], rx_data};
                    cnt  <= cnt + 2'd1;
`ifdef UART_BUS_MASTER_CSUM_EN
                    csum <= csum ^ rx_data;
`endif
                end
                S_DATA: if (rx_read) begin
                    wdata <= {wdata[23:0], rx_data};
                    cnt   <= cnt + 2'd1;
`ifdef UART_BUS_MASTER_CSUM_EN
                    csum  <= csum ^ rx_data;
`endif
                end
`ifdef UART_BUS_MASTER_CSUM_EN
                S_CSUM: if (rx_read) resp_code <= REP_ERR;
`endif
                S_BUS: begin
                    if (mem_ready) begin
                        rdata      <= mem_rdata;
                        resp_code  <= REP_OK;
                        resp_multi <= !is_write;
                    end else if (bus_tmo) begin
                        resp_code  <= REP_TMO;
                    end
`ifdef UART_BUS_MASTER_CSUM_EN
                    resp_tail <= 1'b0;
`endif
                end
                S_RESP: if (tx_fire && resp_multi) begin
                    cnt <= cnt + 2'd1;
`ifdef UART_BUS_MASTER_CSUM_EN
                    if (cnt == 2'd3)
                        resp_tail <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // Bus outputs are gated so they read zero whenever no access is in flight.
    assign mem_valid = (state == S_BUS);
    assign mem_addr  = mem_valid ? (addr & 32'hFFFF_FFFC) : 32'd0;
    assign mem_wdata = mem_valid ? wdata : 32'd0;
    assign mem_wstrb = (mem_valid && is_write) ? 4'hF : 4'h0;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master (default build): directed frame table, corner sequences,
// and random frames checked against a frame-level reference model.
module tb_uart_bus_master;
    localparam int RXT  = 200;
    localparam int BUST = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic        rx_read;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        tx_write;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy;

    uart_bus_master #(.RX_TIMEOUT(RXT), .BUS_TIMEOUT(BUST)) dut (
        .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_ready(rx_ready), .rx_read(rx_read),
        .tx_data(tx_data), .tx_ready(tx_ready), .tx_write(tx_write), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          len;
        bit          ready;
    } acc_t;

    typedef struct {
        logic [71:0] fb;
        int          nb;
        int          lat;
        logic [31:0] rep;
        int          nrep;
        int          nacc;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [3:0]  es;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    acc_t        acc_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          lat = 0;
    bit          hold = 0, noise = 0, tx_rand = 0;
    int          vcount = 0;
    bit          got = 0;
    logic [31:0] cur_a, cur_d;
    logic [3:0]  cur_s;
    int          stab_err = 0, txw_err = 0;
    bit          prev_txw = 0, prev_txr = 1;
    acc_t        ent;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5C3_0F69;
    endfunction

    // Bus responder: memory with configurable wait states, logs each access when valid falls.
    always @(negedge clk) begin
        if (mem_valid) begin
            if (vcount == 0) begin
                cur_a = mem_addr; cur_d = mem_wdata; cur_s = mem_wstrb;
            end else if (mem_addr !== cur_a || mem_wdata !== cur_d || mem_wstrb !== cur_s) begin
                stab_err++;
            end
            vcount++;
            if (!hold && vcount == lat + 1) begin
                mem_ready = 1'b1;
                got = 1'b1;
                if (mem_wstrb == 4'hF) mem[mem_addr] = mem_wdata;
                mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : dflt(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            if (vcount > 0) begin
                ent.addr = cur_a; ent.wdata = cur_d; ent.wstrb = cur_s;
                ent.len = vcount; ent.ready = got;
                acc_q.push_back(ent);
            end
            vcount = 0;
            got = 1'b0;
            mem_ready = noise && ($urandom_range(0, 1) == 1);
            mem_rdata = $urandom;
        end
    end

    // UART tx side: collects bytes and drives tx_ready.
    always @(negedge clk) begin
        if (tx_write) begin
            tx_q.push_back(tx_data);
            if (prev_txw || !prev_txr) txw_err++;
        end
        prev_txw = tx_write;
        tx_ready = tx_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        prev_txr = tx_ready;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // uart_rx keeps rx_ready high one cycle after the read strobe.
    task automatic send_byte(input logic [7:0] b);
        int t;
        @(posedge clk); #1;
        rx_data = b;
        rx_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rx_read && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!rx_read) begin
            chk("rx_read wait", 32'd0, 32'd1);
            rx_ready = 1'b0;
            return;
        end
        @(posedge clk);
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic wait_reply(input int n, input int budget);
        int t;
        t = 0;
        while ((busy || tx_q.size() < n) && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_frame(input string nm, input logic [71:0] fb, input int nb, input int l,
                            input logic [31:0] rep, input int nrep, input int nacc,
                            input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es);
        tx_q.delete();
        acc_q.delete();
        lat = l;
        hold = 1'b0;
        for (int i = 0; i < nb; i++) send_byte(fb[71 - 8*i -: 8]);
        wait_reply(nrep, 600);
        chk({nm, " reply count"}, 32'(tx_q.size()), 32'(nrep));
        for (int i = 0; i < nrep; i++)
            if (i < tx_q.size())
                chk($sformatf("%s reply byte %0d", nm, i), 32'(tx_q[i]), 32'(rep[31 - 8*i -: 8]));
        if (nrep > 0) chk({nm, " tx_data held"}, 32'(tx_data), 32'(rep[31 - 8*(nrep-1) -: 8]));
        chk({nm, " access count"}, 32'(acc_q.size()), 32'(nacc));
        if (nacc > 0 && acc_q.size() > 0) begin
            chk({nm, " addr"}, acc_q[0].addr, ea);
            chk({nm, " wstrb"}, 32'(acc_q[0].wstrb), 32'(es));
            chk({nm, " valid cycles"}, 32'(acc_q[0].len), 32'(l + 1));
            if (es == 4'hF) chk({nm, " wdata"}, acc_q[0].wdata, ed);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   viol, t;
        tbl[0] = '{{8'h57, 32'h80000000, 32'h00000005}, 9, 0, 32'h4B000000, 1, 1, 32'h80000000, 32'h00000005, 4'hF};
        tbl[1] = '{{8'h52, 32'h00000010, 32'h0}, 5, 3, 32'hDEADBEEF, 4, 1, 32'h00000010, 32'h0, 4'h0};
        tbl[2] = '{{8'h41, 64'h0}, 1, 0, 32'h3F000000, 1, 0, 32'h0, 32'h0, 4'h0};
        tbl[3] = '{{8'h52, 32'h80000000, 32'h0}, 5, 1, 32'h00000005, 4, 1, 32'h80000000, 32'h0, 4'h0};
        tbl[4] = '{{8'h57, 32'h00000013, 32'h12345678}, 9, 2, 32'h4B000000, 1, 1, 32'h00000010, 32'h12345678, 4'hF};
        tbl[5] = '{{8'h52, 32'h00000012, 32'h0}, 5, 0, 32'h12345678, 4, 1, 32'h00000010, 32'h0, 4'h0};
        mem[32'h10] = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset mem_valid", 32'(mem_valid), 32'd0);
        chk("reset tx_write", 32'(tx_write), 32'd0);
        chk("reset rx_read", 32'(rx_read), 32'd0);
        chk("reset tx_data", 32'(tx_data), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Partial frame abandoned by silence.
        tx_q.delete(); acc_q.delete();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
        repeat (RXT - 20) @(negedge clk);
        chk("rx timeout still busy", 32'(busy), 32'd1);
        repeat (40) @(negedge clk);
        chk("rx timeout idle", 32'(busy), 32'd0);
        chk("rx timeout no reply", 32'(tx_q.size()), 32'd0);
        chk("rx timeout no access", 32'(acc_q.size()), 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_frame($sformatf("vec%0d", i), tbl[i].fb, tbl[i].nb, tbl[i].lat, tbl[i].rep,
                     tbl[i].nrep, tbl[i].nacc, tbl[i].ea, tbl[i].ed, tbl[i].es);
            if (tbl[i].es == 4'hF) ref_mem[tbl[i].ea] = tbl[i].ed;
        end

        // Read with responder never ready.
        tx_q.delete(); acc_q.delete();
        hold = 1'b1;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        wait_reply(1, 200);
        hold = 1'b0;
        chk("bus timeout reply count", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) chk("bus timeout reply", 32'(tx_q[0]), 32'h54);
        chk("bus timeout access count", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() > 0) begin
            chk("bus timeout valid cycles", 32'(acc_q[0].len), 32'(BUST));
            chk("bus timeout no ready", 32'(acc_q[0].ready), 32'd0);
        end

        // Byte arriving during BUS/RESP must wait until IDLE.
        tx_q.delete(); acc_q.delete();
        lat = 6;
        send_byte(8'h52); send_byte(8'h80); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        @(posedge clk); #1;
        rx_data = 8'h41;
        rx_ready = 1'b1;
        viol = 0;
        t = 0;
        while (t < 400) begin
            @(negedge clk);
            if (busy && rx_read) viol++;
            if (!busy && rx_read) break;
            t++;
        end
        chk("held byte read in idle", 32'(rx_read), 32'd1);
        @(posedge clk);
        @(posedge clk); #1;
        rx_ready = 1'b0;
        wait_reply(5, 200);
        chk("held byte no early read", 32'(viol), 32'd0);
        chk("held byte reply count", 32'(tx_q.size()), 32'd5);
        if (tx_q.size() == 5)
            chk("held byte replies", {tx_q[0], tx_q[1], tx_q[2], tx_q[3]}, 32'h00000005);
        if (tx_q.size() == 5) chk("held byte reply '?'", 32'(tx_q[4]), 32'h3F);

        // Reset during an access.
        tx_q.delete();
        hold = 1'b1;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h30);
        t = 0;
        while (!mem_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("reset mid access valid seen", 32'(mem_valid), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("reset mid access valid drop", 32'(mem_valid), 32'd0);
        chk("reset mid access busy", 32'(busy), 32'd0);
        chk("reset mid access tx_write", 32'(tx_write), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        hold = 1'b0;
        repeat (20) @(negedge clk);
        chk("reset mid access no reply", 32'(tx_q.size()), 32'd0);
        chk("reset mid access tx_data", 32'(tx_data), 32'd0);

        // Random frames against the reference model.
        noise = 1'b1;
        tx_rand = 1'b1;
        for (int k = 0; k < 30; k++) begin
            logic [7:0]  c;
            logic [31:0] a, d, aa, v;
            int          sel, l;
            sel = $urandom_range(0, 9);
            a = 32'h1000_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            aa = a & 32'hFFFF_FFFC;
            d = $urandom;
            l = $urandom_range(0, 5);
            if (sel < 4) begin
                ref_mem[aa] = d;
                do_frame($sformatf("rnd%0d W", k), {8'h57, a, d}, 9, l, 32'h4B000000, 1, 1, aa, d, 4'hF);
            end else if (sel < 8) begin
                v = ref_mem.exists(aa) ? ref_mem[aa] : dflt(aa);
                do_frame($sformatf("rnd%0d R", k), {8'h52, a, 32'h0}, 5, l, v, 4, 1, aa, 32'h0, 4'h0);
            end else begin
                c = 8'($urandom_range(0, 255));
                while (c == 8'h57 || c == 8'h52) c = 8'($urandom_range(0, 255));
                do_frame($sformatf("rnd%0d bad", k), {c, 64'h0}, 1, 0, 32'h3F000000, 1, 0, 32'h0, 32'h0, 4'h0);
            end
        end

        chk("bus fields stable while valid", 32'(stab_err), 32'd0);
        chk("tx_write spacing and ready", 32'(txw_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
